// File: rtl/axilite_uart_mmio_pkg.sv
// Shared definitions for the AXI-Lite UART window: register offsets,
// STAT/CTRL bit positions, response code and FSM state types.
package axilite_uart_mmio_pkg;

  // addr[3:2] register select
  localparam logic [1:0] REG_RX   = 2'd0;
  localparam logic [1:0] REG_TX   = 2'd1;
  localparam logic [1:0] REG_STAT = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  // STAT bit positions
  localparam int STAT_RX_NE   = 0;
  localparam int STAT_RX_FULL = 1;
  localparam int STAT_TX_EMPT = 2;
  localparam int STAT_TX_FULL = 3;
  localparam int STAT_IE      = 4;
  localparam int STAT_OVR     = 5;

  // CTRL bit positions
  localparam int CTRL_FLUSH_TX = 0;
  localparam int CTRL_FLUSH_RX = 1;
  localparam int CTRL_IE       = 4;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_RESP} rstate_t;

  // Snapshot of the flags that make up the STAT word
  typedef struct packed {
    logic ovr;
    logic ie;
    logic tx_full;
    logic tx_empty;
    logic rx_full;
    logic rx_ne;
  } stat_t;

  function automatic logic [31:0] stat_word(input stat_t s);
    logic [31:0] w;
    w = '0;
    w[STAT_RX_NE]   = s.rx_ne;
    w[STAT_RX_FULL] = s.rx_full;
    w[STAT_TX_EMPT] = s.tx_empty;
    w[STAT_TX_FULL] = s.tx_full;
    w[STAT_IE]      = s.ie;
    w[STAT_OVR]     = s.ovr;
    return w;
  endfunction

endpackage

// File: rtl/axilite_uart_mmio_fifo.sv
// 8-bit synchronous FIFO with flush. Pointers carry one extra MSB so
// full and empty are distinguishable; wrap is natural modulo.
module uart_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       gclk,
  input  logic       grst_n,
  input  logic       flush,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0] wp, rp;
  logic [7:0]  mem [DEPTH];
  logic        push_en, pop_en;

  // Full is judged on pre-edge state, so a concurrent pop never lets a
  // push into a full FIFO through.
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout  = mem[rp[AW-1:0]];

  // Pointer update; flush overrides any same-edge push or pop
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push_en) wp <= wp + PTR_ONE;
      if (pop_en)  rp <= rp + PTR_ONE;
    end
  end

  // Storage write; contents need no reset since pointers gate visibility
  always_ff @(posedge gclk) begin
    if (push_en) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/axilite_uart_mmio.sv
// AXI4-Lite slave presenting a UART-lite register window: TX FIFO drains
// to a PS byte stream, RX FIFO is filled from a PS byte stream.
module axilite_uart_mmio
  import axilite_uart_mmio_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  uncoreclk,
  input  logic                  uncore_rstn,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  irq
);

  wstate_t w_q, w_d;
  rstate_t r_q, r_d;

  logic        live;
  logic        w_hs, ar_hs;
  logic [1:0]  w_sel, r_sel;
  logic        tx_push, tx_pop, tx_flush, tx_full, tx_empty, tx_ovf;
  logic        rx_push, rx_pop, rx_flush, rx_full, rx_empty;
  logic [7:0]  rx_dout;
  logic        ctrl_wr, stat_rd;
  logic        ie, ovr;
  logic [31:0] rd_word;

  assign w_sel = s_axi_awaddr[3:2];
  assign r_sel = s_axi_araddr[3:2];

  assign w_hs  = s_axi_awready & s_axi_awvalid & s_axi_wvalid;
  assign ar_hs = s_axi_arready & s_axi_arvalid;

  assign tx_push  = w_hs & (w_sel == REG_TX) & s_axi_wstrb[0];
  assign tx_ovf   = tx_push & tx_full;
  assign ctrl_wr  = w_hs & (w_sel == REG_CTRL);
  assign tx_flush = ctrl_wr & s_axi_wdata[CTRL_FLUSH_TX];
  assign rx_flush = ctrl_wr & s_axi_wdata[CTRL_FLUSH_RX];
  assign rx_pop   = ar_hs & (r_sel == REG_RX);
  assign stat_rd  = ar_hs & (r_sel == REG_STAT);

  assign tx_valid = ~tx_empty;
  assign tx_pop   = tx_valid & tx_ready;
  assign rx_ready = live & ~rx_full;
  assign rx_push  = rx_valid & rx_ready;

  assign s_axi_bresp = RESP_OKAY;
  assign s_axi_rresp = RESP_OKAY;

  // Holds every ready low through reset and the first cycle after it
  always_ff @(posedge uncoreclk or negedge uncore_rstn) begin
    if (!uncore_rstn) live <= 1'b0;
    else              live <= 1'b1;
  end

  uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .gclk   (uncoreclk),
    .grst_n (uncore_rstn),
    .flush  (tx_flush),
    .push   (tx_push),
    .din    (s_axi_wdata[7:0]),
    .pop    (tx_pop),
    .dout   (tx_data),
    .full   (tx_full),
    .empty  (tx_empty)
  );

  uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .gclk   (uncoreclk),
    .grst_n (uncore_rstn),
    .flush  (rx_flush),
    .push   (rx_push),
    .din    (rx_data),
    .pop    (rx_pop),
    .dout   (rx_dout),
    .full   (rx_full),
    .empty  (rx_empty)
  );

  // FSM state registers
  always_ff @(posedge uncoreclk or negedge uncore_rstn) begin
    if (!uncore_rstn) begin
      w_q <= W_IDLE;
      r_q <= R_IDLE;
    end else begin
      w_q <= w_d;
      r_q <= r_d;
    end
  end

  // Next-state logic for both channels
  always_comb begin
    w_d = w_q;
    r_d = r_q;
    case (w_q)
      W_IDLE:  if (w_hs) w_d = W_RESP;
      W_RESP:  if (s_axi_bready) w_d = W_IDLE;
      default: w_d = W_IDLE;
    endcase
    case (r_q)
      R_IDLE:  if (ar_hs) r_d = R_RESP;
      R_RESP:  if (s_axi_rready) r_d = R_IDLE;
      default: r_d = R_IDLE;
    endcase
  end

  // Handshake outputs; AW and W are only accepted together
  always_comb begin
    s_axi_awready = live & (w_q == W_IDLE) & s_axi_awvalid & s_axi_wvalid;
    s_axi_wready  = s_axi_awready;
    s_axi_bvalid  = (w_q == W_RESP);
    s_axi_arready = live & (r_q == R_IDLE);
    s_axi_rvalid  = (r_q == R_RESP);
  end

  // Read data mux; an empty RX reads as zero
  always_comb begin
    rd_word = '0;
    case (r_sel)
      REG_RX:   rd_word = rx_empty ? 32'h0 : {24'h0, rx_dout};
      REG_STAT: rd_word = stat_word('{ovr: ovr, ie: ie, tx_full: tx_full,
                                      tx_empty: tx_empty, rx_full: rx_full,
                                      rx_ne: ~rx_empty});
      default:  rd_word = '0;
    endcase
  end

  // Read data captured on AR handshake, held stable while rvalid waits
  always_ff @(posedge uncoreclk or negedge uncore_rstn) begin
    if (!uncore_rstn)  s_axi_rdata <= '0;
    else if (ar_hs)    s_axi_rdata <= rd_word;
  end

  // Interrupt enable and sticky overflow; a same-edge overflow beats the STAT clear
  always_ff @(posedge uncoreclk or negedge uncore_rstn) begin
    if (!uncore_rstn) begin
      ie  <= 1'b0;
      ovr <= 1'b0;
    end else begin
      if (ctrl_wr) ie <= s_axi_wdata[CTRL_IE];
      if (tx_ovf)       ovr <= 1'b1;
      else if (stat_rd) ovr <= 1'b0;
    end
  end

  // Registered level interrupt
  always_ff @(posedge uncoreclk or negedge uncore_rstn) begin
    if (!uncore_rstn) irq <= 1'b0;
    else              irq <= ie & (~rx_empty | tx_empty);
  end

  logic unused_ok;
  assign unused_ok = ^{s_axi_awaddr[ADDR_WIDTH-1:4], s_axi_awaddr[1:0],
                       s_axi_araddr[ADDR_WIDTH-1:4], s_axi_araddr[1:0],
                       s_axi_wdata[31:8], s_axi_wstrb[3:1]};

endmodule

// File: tb/tb_axilite_uart_mmio.sv
// Directed bench for axilite_uart_mmio: a register-op table plus hand
// sequences for stream ordering, overflow, backpressure, flush and reset.
module tb_axilite_uart_mmio;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready, irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axilite_uart_mmio #(.FIFO_DEPTH(16), .ADDR_WIDTH(32)) dut (
    .uncoreclk     (clk),
    .uncore_rstn   (rstn),
    .s_axi_awaddr  (awaddr),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .irq           (irq)
  );

  typedef struct {
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] wd;
    logic [3:0]  st;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Returns at the negedge after the AW/W handshake, with bready high
  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    @(negedge clk);
    awaddr = {28'h0, a}; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    #1;
    while (!awready && n < 20) begin @(negedge clk); #1; n++; end
    if (!awready) begin
      chk("awready_timeout", {31'h0, awready}, 32'h1);
      awvalid = 1'b0; wvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    chk("bvalid", {31'h0, bvalid}, 32'h1);
    chk("bresp", {30'h0, bresp}, 32'h0);
  endtask

  // Returns at the negedge after the AR handshake with the captured rdata
  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    int n;
    d = 32'hDEAD_BEEF;
    @(negedge clk);
    araddr = {28'h0, a}; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    #1;
    while (!arready && n < 20) begin @(negedge clk); #1; n++; end
    if (!arready) begin
      chk("arready_timeout", {31'h0, arready}, 32'h1);
      arvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    chk("rvalid", {31'h0, rvalid}, 32'h1);
    chk("rresp", {30'h0, rresp}, 32'h0);
    d = rdata;
  endtask

  task automatic push_rx(input logic [7:0] b);
    @(negedge clk);
    rx_data = b; rx_valid = 1'b1;
    chk("rx_ready_push", {31'h0, rx_ready}, 32'h1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  vec_t tbl[14];
  logic [31:0] rd;

  initial begin
    rstn = 1'b0;
    awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
    araddr = '0; arvalid = 0; rready = 0;
    tx_ready = 0; rx_data = '0; rx_valid = 0;

    // ---- reset state ----
    #12;
    chk("rst_arready", {31'h0, arready}, 32'h0);
    chk("rst_rx_ready", {31'h0, rx_ready}, 32'h0);
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_bvalid", {31'h0, bvalid}, 32'h0);
    chk("rst_rvalid", {31'h0, rvalid}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    @(negedge clk); rstn = 1'b1;
    @(negedge clk);

    // ---- register table ----
    tbl[0]  = '{0, 4'h8, 32'h0,   4'h0, 32'h04};
    tbl[1]  = '{0, 4'h0, 32'h0,   4'h0, 32'h00};
    tbl[2]  = '{0, 4'hC, 32'h0,   4'h0, 32'h00};
    tbl[3]  = '{1, 4'h4, 32'h141, 4'h0, 32'h0};
    tbl[4]  = '{0, 4'h8, 32'h0,   4'h0, 32'h04};
    tbl[5]  = '{1, 4'h4, 32'h1A5, 4'h1, 32'h0};
    tbl[6]  = '{0, 4'h8, 32'h0,   4'h0, 32'h00};
    tbl[7]  = '{1, 4'hC, 32'h10,  4'hF, 32'h0};
    tbl[8]  = '{0, 4'h8, 32'h0,   4'h0, 32'h10};
    tbl[9]  = '{1, 4'hC, 32'h11,  4'hF, 32'h0};
    tbl[10] = '{0, 4'h8, 32'h0,   4'h0, 32'h14};
    tbl[11] = '{1, 4'h0, 32'hFF,  4'hF, 32'h0};
    tbl[12] = '{1, 4'hC, 32'h00,  4'hF, 32'h0};
    tbl[13] = '{0, 4'h8, 32'h0,   4'h0, 32'h04};
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].wr) axi_write(tbl[i].addr, tbl[i].wd, tbl[i].st);
      else begin
        axi_read(tbl[i].addr, rd);
        chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp);
      end
    end

    // ---- TX ordering under stream backpressure ----
    axi_write(4'h4, 32'h41, 4'h1);
    axi_write(4'h4, 32'h42, 4'h1);
    @(negedge clk);
    chk("t1_tx_valid", {31'h0, tx_valid}, 32'h1);
    chk("t1_tx_data0", {24'h0, tx_data}, 32'h41);
    tx_ready = 1'b1;
    @(negedge clk);
    chk("t1_tx_data1", {24'h0, tx_data}, 32'h42);
    @(negedge clk);
    chk("t1_tx_drained", {31'h0, tx_valid}, 32'h0);
    tx_ready = 1'b0;
    axi_read(4'h8, rd); chk("t1_stat", rd, 32'h04);

    // ---- TX overflow and ovr clear-on-read ----
    for (int i = 0; i < 16; i++) axi_write(4'h4, 32'h10 + i, 4'h1);
    axi_write(4'h4, 32'h99, 4'h1);
    axi_read(4'h8, rd); chk("t2_stat_ovr", rd, 32'h28);
    axi_read(4'h8, rd); chk("t2_stat_clr", rd, 32'h08);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      tx_ready = 1'b1;
      chk($sformatf("t2_drain%0d", i), {23'h0, tx_valid, tx_data}, {23'h1, 8'(32'h10 + i)});
    end
    @(negedge clk);
    chk("t2_no_extra", {31'h0, tx_valid}, 32'h0);
    tx_ready = 1'b0;

    // ---- RX push/pop, empty read, RX full ----
    push_rx(8'h55);
    axi_read(4'h0, rd); chk("t3_rx_byte", rd, 32'h55);
    axi_read(4'h0, rd); chk("t3_rx_empty", rd, 32'h0);
    for (int i = 0; i < 16; i++) push_rx(8'h60 + 8'(i));
    @(negedge clk);
    chk("t3_rx_full_ready", {31'h0, rx_ready}, 32'h0);
    axi_read(4'h8, rd); chk("t3_stat", rd, 32'h07);
    axi_read(4'h0, rd); chk("t3_rx_first", rd, 32'h60);
    @(negedge clk);
    chk("t3_rx_ready_back", {31'h0, rx_ready}, 32'h1);
    axi_write(4'hC, 32'h02, 4'hF);

    // ---- AW before W, B backpressure ----
    @(negedge clk);
    awaddr = 32'h4; wdata = 32'h77; wstrb = 4'h1; awvalid = 1'b1; bready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("t4_aw_wait%0d", i), {31'h0, awready}, 32'h0);
      @(negedge clk);
    end
    wvalid = 1'b1;
    #1 chk("t4_awready", {30'h0, awready, wready}, 32'h3);
    @(posedge clk); #1;
    wdata = 32'h88;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t4_hold%0d", i), {29'h0, bvalid, awready, wready}, 32'h4);
      @(negedge clk);
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(negedge clk);
    chk("t4_bdone", {31'h0, bvalid}, 32'h0);
    chk("t4_tx_one", {23'h0, tx_valid, tx_data}, {23'h1, 8'h77});
    tx_ready = 1'b1;
    @(negedge clk);
    chk("t4_tx_only_one", {31'h0, tx_valid}, 32'h0);
    tx_ready = 1'b0;

    // ---- flush both FIFOs and enable irq ----
    for (int i = 0; i < 8; i++) axi_write(4'h4, 32'h30 + i, 4'h1);
    for (int i = 0; i < 8; i++) push_rx(8'h70 + 8'(i));
    axi_read(4'h8, rd); chk("t5_stat_half", rd, 32'h01);
    axi_write(4'hC, 32'h13, 4'hF);
    chk("t5_tx_flushed", {31'h0, tx_valid}, 32'h0);
    chk("t5_rx_ready", {31'h0, rx_ready}, 32'h1);
    chk("t5_irq_lag", {31'h0, irq}, 32'h0);
    @(negedge clk);
    chk("t5_irq", {31'h0, irq}, 32'h1);
    axi_read(4'h8, rd); chk("t5_stat", rd, 32'h14);

    // ---- reset with a read response outstanding ----
    push_rx(8'hAB);
    axi_write(4'h4, 32'hCD, 4'h1);
    @(negedge clk);
    araddr = 32'h8; arvalid = 1'b1; rready = 1'b0;
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    chk("t6_rvalid_pending", {31'h0, rvalid}, 32'h1);
    #2 rstn = 1'b0;
    #1;
    chk("t6_rvalid_rst", {31'h0, rvalid}, 32'h0);
    chk("t6_tx_empty", {31'h0, tx_valid}, 32'h0);
    chk("t6_irq_rst", {31'h0, irq}, 32'h0);
    chk("t6_rdata_rst", rdata, 32'h0);
    @(negedge clk); rstn = 1'b1; rready = 1'b1;
    axi_read(4'h8, rd); chk("t6_stat_after", rd, 32'h04);
    axi_read(4'h0, rd); chk("t6_rx_after", rd, 32'h0);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time guard so the bench cannot hang
  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded, checks %0d", checks);
    $fatal(1, "timeout");
  end

endmodule
